// File: rtl/top_double_case2_seq_if.sv
// Job control, configuration port and the two AXI-style output streams of top_double_case2_seq.
interface top_double_case2_seq_if #(
   parameter int J = 14
);
   logic            start;
   logic            busy;
   logic            done;
   logic            cfg_we;
   logic            cfg_sel;
   logic [7:0]      cfg_addr;
   logic [63:0]     cfg_wdata;
   logic            cfg_err;
   logic [J-1:0]    H_row;
   logic            H_row_tvalid;
   logic            H_row_tready;
   logic            H_row_tlast;
   logic [J*64-1:0] alpha_u_col;
   logic            alpha_u_col_tvalid;
   logic            alpha_u_col_tready;
   logic            alpha_u_col_tlast;

   modport master (
      output start, cfg_we, cfg_sel, cfg_addr, cfg_wdata, H_row_tready, alpha_u_col_tready,
      input  busy, done, cfg_err, H_row, H_row_tvalid, H_row_tlast,
             alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
   );

   modport slave (
      input  start, cfg_we, cfg_sel, cfg_addr, cfg_wdata, H_row_tready, alpha_u_col_tready,
      output busy, done, cfg_err, H_row, H_row_tvalid, H_row_tlast,
             alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast
   );
endinterface

// File: rtl/top_double_case2_seq.sv
// Sequencer for the top_double_case2 datapath: holds the H-row and alpha tables and,
// per start, streams all H rows followed by all alpha columns.
module top_double_case2_seq #(
   parameter int J    = 14,
   parameter int NROW = 7,
   parameter int I    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   top_double_case2_seq_if.slave bus
);
   // state  | meaning
   // IDLE   | waiting for start; config writes accepted
   // H_SEND | streaming H rows 0..NROW-1
   // A_SEND | streaming alpha columns 0..I-1
   // DONE   | single completion cycle, done=1
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_H_SEND = 2'd1;
   localparam logic [1:0] S_A_SEND = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int HW = (NROW > 1) ? $clog2(NROW) : 1;
   localparam int CW = (I > 1) ? $clog2(I) : 1;
   localparam int EW = (J > 1) ? $clog2(J) : 1;

   logic [1:0]      r_state;
   logic [HW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic            r_cfg_err;
   logic [J-1:0]    r_h     [NROW];
   logic [63:0]     r_alpha [I][J];

   logic            w_busy;
   logic            w_h_valid;
   logic            w_a_valid;
   logic            w_h_last;
   logic            w_a_last;
   logic            w_h_wr;
   logic            w_a_wr;
   logic [HW-1:0]   w_h_idx;
   logic [CW-1:0]   w_a_col;
   logic [EW-1:0]   w_a_elem;
   logic [J*64-1:0] w_col;

   assign w_busy    = (r_state != S_IDLE);
   assign w_h_valid = (r_state == S_H_SEND);
   assign w_a_valid = (r_state == S_A_SEND);
   assign w_h_last  = (r_row == HW'(NROW - 1));
   assign w_a_last  = (r_col == CW'(I - 1));

   // Writes are only legal while idle so a running job always streams a consistent table.
   assign w_h_wr   = bus.cfg_we && !w_busy && !bus.cfg_sel && (int'(bus.cfg_addr) < NROW);
   assign w_a_wr   = bus.cfg_we && !w_busy &&  bus.cfg_sel && (int'(bus.cfg_addr) < I * J);
   assign w_h_idx  = bus.cfg_addr[HW-1:0];
   assign w_a_col  = CW'(int'(bus.cfg_addr) / J);
   assign w_a_elem = EW'(int'(bus.cfg_addr) % J);

   always_comb begin
      w_col = '0;
      for (int e = 0; e < J; e++) begin
         w_col[e*64 +: 64] = r_alpha[r_col][e];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_err <= 1'b0;
         for (int r = 0; r < NROW; r++) begin
            r_h[r] <= '0;
         end
         for (int c = 0; c < I; c++) begin
            for (int e = 0; e < J; e++) begin
               r_alpha[c][e] <= '0;
            end
         end
      end else begin
         r_cfg_err <= bus.cfg_we && !(w_h_wr || w_a_wr);
         if (w_h_wr) begin
            r_h[w_h_idx] <= bus.cfg_wdata[J-1:0];
         end
         if (w_a_wr) begin
            r_alpha[w_a_col][w_a_elem] <= bus.cfg_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_H_SEND;
                  r_row   <= '0;
                  r_col   <= '0;
               end
            end
            S_H_SEND: begin
               if (bus.H_row_tready) begin
                  if (w_h_last) begin
                     r_state <= S_A_SEND;
                     r_col   <= '0;
                  end else begin
                     r_row <= r_row + HW'(1);
                  end
               end
            end
            S_A_SEND: begin
               if (bus.alpha_u_col_tready) begin
                  if (w_a_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Data and tlast are gated by valid so idle outputs read as zero.
   assign bus.busy               = w_busy;
   assign bus.done               = (r_state == S_DONE);
   assign bus.cfg_err            = r_cfg_err;
   assign bus.H_row_tvalid       = w_h_valid;
   assign bus.H_row              = w_h_valid ? r_h[r_row] : '0;
   assign bus.H_row_tlast        = w_h_valid && w_h_last;
   assign bus.alpha_u_col_tvalid = w_a_valid;
   assign bus.alpha_u_col        = w_a_valid ? w_col : '0;
   assign bus.alpha_u_col_tlast  = w_a_valid && w_a_last;
endmodule

// File: tb/tb_top_double_case2_seq.sv
// Directed/randomized bench for top_double_case2_seq against a table-and-queue model of one job.
module tb_top_double_case2_seq;
   localparam int J = 14, NROW = 7, I = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0, n_fail = 0;

   logic [J-1:0] m_h [NROW];
   logic [63:0]  m_a [I*J];

   top_double_case2_seq_if #(.J(J)) bus ();

   top_double_case2_seq #(.J(J), .NROW(NROW), .I(I)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while idle; rejected writes must not touch the model.
   task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [63:0] data);
      bit ok;
      ok = (sel == 1'b0) ? (int'(addr) < NROW) : (int'(addr) < I * J);
      bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_addr = addr; bus.cfg_wdata = data;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      chk($sformatf("cfg_err_sel%0d_addr%0d", sel, addr), bus.cfg_err, !ok);
      if (ok) begin
         if (sel == 1'b0) m_h[addr] = data[J-1:0];
         else             m_a[addr] = data;
      end
      @(negedge clk);
      chk("cfg_err_one_cycle", bus.cfg_err, 0);
   endtask

   // mode 0: tready=1, mode 1: tready 1,0,1,0.., mode 2: random tready
   task automatic run_job(input int mode, input bit glitch, input bit busy_wr,
                          input bit start_wr, input int exp_lat);
      int row = 0, col = 0, dones = 0, done_cyc = -1, first_h = -1;
      bit trdy;
      logic [63:0] wd;
      bus.start = 1'b1;
      if (start_wr) begin
         wd = {$urandom, $urandom};
         bus.cfg_we = 1'b1; bus.cfg_sel = 1'b0; bus.cfg_addr = 8'd0; bus.cfg_wdata = wd;
         m_h[0] = wd[J-1:0];
      end
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         bus.start  = glitch && (cyc == 3);
         bus.cfg_we = busy_wr && (cyc == 2);
         if (bus.cfg_we) begin
            bus.cfg_sel = 1'b0; bus.cfg_addr = 8'(NROW - 1); bus.cfg_wdata = {$urandom, $urandom};
         end
         if (start_wr && cyc == 1) chk("cfg_err_start_wr", bus.cfg_err, 0);
         if (busy_wr && cyc == 3)  chk("cfg_err_busy", bus.cfg_err, 1);
         if (mode == 0)      trdy = 1'b1;
         else if (mode == 1) trdy = (cyc % 2 == 1);
         else                trdy = 1'($urandom_range(0, 1));
         bus.H_row_tready = trdy;
         bus.alpha_u_col_tready = trdy;
         chk("both_valid", bus.H_row_tvalid & bus.alpha_u_col_tvalid, 0);
         if (done_cyc < 0) chk("busy_in_job", bus.busy, 1);
         if (bus.H_row_tvalid) begin
            if (first_h < 0) first_h = cyc;
            chk("h_row_idx_range", (row < NROW) && (col == 0), 1);
            if (row < NROW) begin
               chk($sformatf("h_row%0d_data", row), bus.H_row, m_h[row]);
               chk($sformatf("h_row%0d_tlast", row), bus.H_row_tlast, row == NROW - 1);
            end
            if (trdy) row++;
         end
         if (bus.alpha_u_col_tvalid) begin
            chk("a_order", (row == NROW) && (col < I), 1);
            if (col < I) begin
               for (int e = 0; e < J; e++)
                  chk($sformatf("a_col%0d_elem%0d", col, e), bus.alpha_u_col[e*64 +: 64], m_a[col*J + e]);
               chk($sformatf("a_col%0d_tlast", col), bus.alpha_u_col_tlast, col == I - 1);
            end
            if (trdy) col++;
         end
         if (bus.done) begin
            dones++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               chk("done_after_all_beats", row * 16 + col, NROW * 16 + I);
            end
         end
         if (done_cyc > 0 && cyc == done_cyc + 1) chk("busy_after_done", bus.busy, 0);
         if (done_cyc > 0 && cyc >= done_cyc + 4) break;
      end
      bus.start = 1'b0;
      bus.cfg_we = 1'b0;
      chk("job_finished", done_cyc > 0, 1);
      chk("first_h_cycle", first_h, 1);
      chk("one_done_pulse", dones, 1);
      if (exp_lat > 0) chk("start_to_done_cycles", done_cyc, exp_lat);
   endtask

   initial begin
      logic [J-1:0] rows [NROW];
      rows = '{14'h18A3, 14'h0D4A, 14'h14C5, 14'h230B, 14'h22B4, 14'h2538, 14'h1A54};
      bus.start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_sel = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
      bus.H_row_tready = 1'b0; bus.alpha_u_col_tready = 1'b0;
      for (int r = 0; r < NROW; r++) m_h[r] = '0;
      for (int a = 0; a < I*J; a++) m_a[a] = '0;

      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_h_tvalid", bus.H_row_tvalid, 0);
      chk("rst_a_tvalid", bus.alpha_u_col_tvalid, 0);
      chk("rst_cfg_err", bus.cfg_err, 0);
      chk("rst_h_row", bus.H_row, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reference load, then a full-throughput job
      for (int r = 0; r < NROW; r++) cfg_write(1'b0, 8'(r), 64'(rows[r]));
      for (int a = 0; a < I*J; a++)  cfg_write(1'b1, 8'(a), {$urandom, $urandom});
      run_job(0, 1'b0, 1'b0, 1'b0, 10);

      cfg_write(1'b1, 8'd13, 64'h3FF0000000000000);
      run_job(1, 1'b0, 1'b0, 1'b0, 0);

      cfg_write(1'b0, 8'd7, {$urandom, $urandom});
      cfg_write(1'b1, 8'(I*J), {$urandom, $urandom});
      cfg_write(1'b0, 8'hFF, {$urandom, $urandom});
      run_job(2, 1'b0, 1'b1, 1'b0, 0);
      run_job(0, 1'b1, 1'b0, 1'b0, 10);
      run_job(0, 1'b0, 1'b0, 1'b1, 10);
      run_job(2, 1'b1, 1'b1, 1'b0, 0);

      // Reset while column 1 is on the alpha stream
      bus.H_row_tready = 1'b1; bus.alpha_u_col_tready = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      chk("a_col1_before_rst", bus.alpha_u_col_tvalid & bus.alpha_u_col_tlast, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_a_tvalid", bus.alpha_u_col_tvalid, 0);
      chk("rst_mid_h_tvalid", bus.H_row_tvalid, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_a_tlast", bus.alpha_u_col_tlast, 0);
      chk("rst_mid_done", bus.done, 0);
      for (int r = 0; r < NROW; r++) m_h[r] = '0;
      for (int a = 0; a < I*J; a++) m_a[a] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_after_rst_busy", bus.busy, 0);
         chk("idle_after_rst_h_tvalid", bus.H_row_tvalid, 0);
      end
      run_job(0, 1'b0, 1'b0, 1'b0, 10);
      cfg_write(1'b0, 8'd3, {$urandom, $urandom});
      cfg_write(1'b1, 8'd20, {$urandom, $urandom});
      run_job(1, 1'b0, 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
